div_result_queue: RTL and testbench
===================================

DIV_RESULT_QUEUE -- requirements
Module: div_result_queue

Interface
REQ-001 Parameter DATA_W, default 8, width of the quotient and remainder fields.
REQ-002 Parameter DEPTH, default 4, number of entries; the block SHALL support only powers of two >= 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream divider result is present this cycle.
REQ-006 in_ready  output  1  queue accepts a result this cycle.
REQ-007 in_quotient  input  DATA_W  divider quotient.
REQ-008 in_remainder  input  DATA_W  divider remainder.
REQ-009 in_dbz  input  1  divisor was zero for this result.
REQ-010 out_valid  output  1  head entry available downstream.
REQ-011 out_ready  input  1  downstream consumes the head entry this cycle.
REQ-012 out_quotient  output  DATA_W  head entry quotient.
REQ-013 out_remainder  output  DATA_W  head entry remainder.
REQ-014 out_dbz  output  1  head entry divide-by-zero flag.
REQ-015 count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 drop_err  output  1  sticky flag: a result was offered while full.

Function
REQ-017 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL equal (count != DEPTH); a same-cycle pop SHALL NOT raise in_ready when full.
REQ-019 out_valid SHALL equal (count != 0).
REQ-020 out_quotient, out_remainder and out_dbz SHALL reflect the head entry whenever out_valid is 1, and SHALL be all zero whenever out_valid is 0.
REQ-021 A pushed entry SHALL appear at the outputs no earlier than the cycle after the push; there is no combinational in-to-out path.
REQ-022 Ordering SHALL be strict FIFO; entry fields SHALL be stored unmodified, with no arithmetic on the data.
REQ-023 Write and read pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 without a gap.
REQ-024 A simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged.
REQ-025 A simultaneous push and pop at count == 0 is impossible, because out_valid is 0; the push alone SHALL take effect.
REQ-026 in_valid=1 while in_ready=0 SHALL set drop_err, which stays 1 until reset; the offered data SHALL be discarded and no stored state SHALL change.
REQ-027 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-028 Asserting rst_n low SHALL immediately clear count, both pointers and drop_err, and force out_valid=0, in_ready=1 and all data outputs to 0, including mid-transfer.
REQ-029 Storage contents need not be cleared; they SHALL be unobservable until rewritten.
REQ-030 The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-031 A shared package div_pkg SHALL hold DATA_W, DEPTH and the div_result_t struct {quotient, remainder, dbz}; this package is reused by the divider wrapper.
REQ-032 The block SHALL be a single module with no sub-module; storage is a DEPTH-entry array of div_result_t, with separate pointer and occupancy counters.

Verification
REQ-033 Reset, then push (q=0x05, r=0x02, dbz=0) -> next cycle out_valid=1, out_quotient=0x05, out_remainder=0x02, count=1.
REQ-034 Push 4 entries (q=1..4) with out_ready=0 -> count=4 and in_ready=0; a fifth offer sets drop_err=1 and count stays 4; draining then yields q=1,2,3,4 in order.
REQ-035 Hold count=2 and assert push and pop together for 10 cycles -> count stays 2, the pointers wrap past 3->0, and the output order matches the input order.
REQ-036 Push (q=0, r=0, dbz=1) -> out_dbz=1 at the head; after the pop, out_valid=0 and all outputs=0.
REQ-037 Fill 3 entries, pulse rst_n low mid-cycle -> outputs clear asynchronously; after release count=0, drop_err=0 and in_ready=1.
REQ-038 Random valid/ready stress for 10k cycles against a reference queue model -> no loss, duplication or reordering, and count always matches the model.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared divider result widths and entry type
package div_pkg;
  localparam int DATA_W = 8;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              dbz;
  } div_result_t;
endpackage

// File: rtl/div_result_queue.sv
// div_result_queue: FIFO buffering divider results, with a sticky overflow flag
module div_result_queue #(
  parameter int DATA_W = div_pkg::DATA_W,
  parameter int DEPTH = div_pkg::DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_quotient,
  input  logic [DATA_W-1:0] in_remainder,
  input  logic              in_dbz,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_quotient,
  output logic [DATA_W-1:0] out_remainder,
  output logic              out_dbz,
  output logic [AW:0]       count,
  output logic              drop_err
);
  import div_pkg::*;
  div_result_t       mem_q [DEPTH];
  div_result_t       head;
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic              drop_q, drop_d, push, pop;
  always_comb begin
    in_ready = count_q != (AW+1)'(DEPTH);
    out_valid = count_q != '0;
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    drop_d = drop_q || (in_valid && !in_ready);
    // Gating on out_valid hides stale storage after reset or drain
    head = out_valid ? mem_q[rptr_q] : '0;
    out_quotient = head.quotient;
    out_remainder = head.remainder;
    out_dbz = head.dbz;
    count = count_q;
    drop_err = drop_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      drop_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q] <= '{quotient: in_quotient, remainder: in_remainder, dbz: in_dbz};
endmodule

// File: tb/tb_div_result_queue.sv
// tb_div_result_queue: directed and random checks against a queue reference model
module tb_div_result_queue;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_dbz = 0, out_ready = 0;
  logic [DW-1:0] in_quotient = 0, in_remainder = 0;
  logic in_ready, out_valid, out_dbz, drop_err;
  logic [DW-1:0] out_quotient, out_remainder;
  logic [2:0] count;
  int n_cmp = 0, n_err = 0;
  logic [16:0] mq[$];
  logic m_drop = 0;

  div_result_queue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_quotient(in_quotient), .in_remainder(in_remainder), .in_dbz(in_dbz),
    .out_valid(out_valid), .out_ready(out_ready), .out_quotient(out_quotient),
    .out_remainder(out_remainder), .out_dbz(out_dbz), .count(count), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [16:0] h;
    h = mq.size() > 0 ? mq[0] : 17'h0;
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() < DEPTH));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    chk({tag, ".quot"}, 32'(out_quotient), 32'(h[7:0]));
    chk({tag, ".rem"}, 32'(out_remainder), 32'(h[15:8]));
    chk({tag, ".dbz"}, 32'(out_dbz), 32'(h[16]));
    chk({tag, ".drop"}, 32'(drop_err), 32'(m_drop));
  endtask

  task automatic step(input string tag, input logic v, input logic [7:0] q, input logic [7:0] r,
                      input logic z, input logic rd);
    logic pu, po;
    in_valid = v; in_quotient = q; in_remainder = r; in_dbz = z; out_ready = rd;
    pu = v && mq.size() < DEPTH;
    po = rd && mq.size() > 0;
    if (v && !pu) m_drop = 1;
    @(posedge clk);
    if (po) void'(mq.pop_front());
    if (pu) mq.push_back({z, r, q});
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    #12 check_all("reset");
    @(negedge clk) rst_n = 1;
    step("push05", 1, 8'h05, 8'h02, 0, 0);
    chk("push05.q_const", 32'(out_quotient), 32'h05);
    chk("push05.r_const", 32'(out_remainder), 32'h02);
    step("drain1", 0, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) step("fill", 1, 8'(i), 8'(i + 16), 0, 0);
    chk("full.count", 32'(count), 32'd4);
    chk("full.in_ready", 32'(in_ready), 32'd0);
    step("overflow", 1, 8'h55, 8'h66, 1, 0);
    chk("overflow.drop", 32'(drop_err), 32'd1);
    step("full_pushpop", 1, 8'h77, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) step("drain", 0, 0, 0, 0, 1);
    step("idle_pop", 0, 0, 0, 0, 1);
    step("pp_a", 1, 8'hA0, 8'h10, 0, 0);
    step("pp_b", 1, 8'hA1, 8'h11, 1, 0);
    for (int i = 2; i < 12; i++) step("pushpop", 1, 8'(8'hA0 + i), 8'(8'h10 + i), 1'(i % 2), 1);
    chk("pushpop.count", 32'(count), 32'd2);
    step("pp_d1", 0, 0, 0, 0, 1);
    step("pp_d2", 0, 0, 0, 0, 1);
    step("dbz_push", 1, 8'h00, 8'h00, 1, 0);
    chk("dbz.head", 32'(out_dbz), 32'd1);
    step("dbz_pop", 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("fill3", 1, 8'(8'hC0 + i), 8'(8'hD0 + i), 1, 0);
    in_valid = 0; out_ready = 0;
    #3 rst_n = 0;
    mq.delete(); m_drop = 0;
    #1 check_all("async_rst");
    @(negedge clk) rst_n = 1;
    check_all("post_rst");
    step("first_push", 1, 8'h3C, 8'h4D, 0, 0);
    for (int i = 0; i < 10000; i++)
      step("rand", 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
